// File: rtl/vita49_pack.sv
// VITA49 IF-data-with-stream-ID packetizer: header, stream ID, TSI, TSF, payload, optional trailer.
// Optional trailer word is enabled by defining VITA49_PACK_TRAILER_EN.
module vita49_pack #(
    parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4
) (
    input  logic                                 AXIS_ACLK,
    input  logic                                 AXIS_ARESETN,
    input  logic                                 S_AXIS_TVALID,
    output logic                                 S_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_NUM_BYTES*8-1:0]  S_AXIS_TDATA,
    output logic                                 M_AXIS_TVALID,
    input  logic                                 M_AXIS_TREADY,
    output logic [C_AXIS_TDATA_NUM_BYTES*8-1:0]  M_AXIS_TDATA,
    output logic                                 M_AXIS_TLAST,
    input  logic [31:0]                          tsi,
    input  logic [63:0]                          tsf,
    input  logic                                 enable,
    input  logic [31:0]                          stream_id,
    input  logic [11:0]                          payload_len,
    output logic                                 busy,
    output logic [3:0]                           pkt_count
);

    localparam int unsigned DW = C_AXIS_TDATA_NUM_BYTES * 8;
    localparam int unsigned LW = 13;

`ifdef VITA49_PACK_TRAILER_EN
    localparam logic        TRL_EN    = 1'b1;
    localparam logic [15:0] HDR_EXTRA = 16'd6;
    localparam logic [31:0] TRAILER   = 32'h4004_0000;
`else
    localparam logic        TRL_EN    = 1'b0;
    localparam logic [15:0] HDR_EXTRA = 16'd5;
`endif

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SID,
        TSI,
        TSFH,
        TSFL,
        PAY
`ifdef VITA49_PACK_TRAILER_EN
        , TRL
`endif
    } state_t;

    state_t          state;
    logic [31:0]     tsi_q;
    logic [63:0]     tsf_q;
    logic [31:0]     sid_q;
    logic [LW-1:0]   rem_q;

    logic            out_load;
    logic            tlast_hs;
    logic [3:0]      hdr_count;
    logic [31:0]     hdr_word;
    logic            pay_last;

    // Output register may load when empty or when its word is being taken this cycle.
    assign out_load  = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign tlast_hs  = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
    assign S_AXIS_TREADY = (state == PAY) && out_load;
    assign pay_last  = (rem_q == LW'(1));

    // A previous packet's TLAST may still be handshaking while the header loads.
    assign hdr_count = pkt_count + 4'(tlast_hs);
    assign hdr_word  = {4'b0001, 1'b0, TRL_EN, 2'b00, 2'b01, 2'b01, hdr_count,
                        16'(rem_q) + HDR_EXTRA};

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state         <= IDLE;
            tsi_q         <= '0;
            tsf_q         <= '0;
            sid_q         <= '0;
            rem_q         <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            busy          <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (tlast_hs) begin
                pkt_count <= pkt_count + 4'd1;
            end
            // Drain by default; any state that emits a word overrides below.
            if (out_load) begin
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tlast_hs) begin
                        busy <= 1'b0;
                    end
                    if (enable && S_AXIS_TVALID) begin
                        tsi_q <= tsi;
                        tsf_q <= tsf;
                        sid_q <= stream_id;
                        rem_q <= (payload_len == 12'd0) ? LW'(4096) : LW'(payload_len);
                        busy  <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(hdr_word);
                    state         <= SID;
                end
                SID: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(sid_q);
                    state         <= TSI;
                end
                TSI: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(tsi_q);
                    state         <= TSFH;
                end
                TSFH: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(tsf_q[63:32]);
                    state         <= TSFL;
                end
                TSFL: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(tsf_q[31:0]);
                    state         <= PAY;
                end
                PAY: if (S_AXIS_TREADY && S_AXIS_TVALID) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= S_AXIS_TDATA;
                    M_AXIS_TLAST  <= pay_last && !TRL_EN;
                    rem_q         <= rem_q - LW'(1);
                    if (pay_last) begin
`ifdef VITA49_PACK_TRAILER_EN
                        state <= TRL;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef VITA49_PACK_TRAILER_EN
                TRL: if (out_load) begin
                    M_AXIS_TVALID <= 1'b1;
                    M_AXIS_TDATA  <= DW'(TRAILER);
                    M_AXIS_TLAST  <= 1'b1;
                    state         <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
